// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI port controller: FSM states, pad drive
// bundle, synchroniser reset values and the slave-select index width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_HOLD
    } spi_state_e;

    typedef struct packed {
        logic mosi_o;
        logic mosi_oe;
        logic miso_o;
        logic miso_oe;
        logic sck_o;
        logic sck_oe;
        logic ss_oe;
        logic data_in;
    } pad_drv_t;

    // Idle-high lines reset high so no false edge or select appears after reset.
    localparam logic SYNC_RST_SS  = 1'b1;
    localparam logic SYNC_RST_SCK = 1'b1;
    localparam logic SYNC_RST_DAT = 1'b0;

    function automatic int ss_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pad input synchroniser with a configurable reset value and
// single-cycle rise/fall pulses of the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise =  q & ~prev_q;
    assign fall = ~q &  prev_q;

endmodule

// File: rtl/spi_port_ctrl_mc.sv
// SPI pad steering: synchronised slave inputs, registered pad drive, auto slave
// select sequencing with setup/hold timing, and sticky mode-fault detection.
module spi_port_ctrl_mc
    import spi_pkg::*;
#(
    parameter int NUM_SS       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SS_SETUP_CYC = 2,
    parameter int SS_HOLD_CYC  = 2,
    localparam int IW          = ss_idx_w(NUM_SS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mstr,
    input  logic              modfen,
    input  logic              ssoe,
    input  logic [IW-1:0]     ss_idx,
    input  logic              xfer_req,
    input  logic              shift_done,
    input  logic              sck_out,
    input  logic              data_out,
    input  logic              modf_clr,
    input  logic              mosi_i,
    input  logic              miso_i,
    input  logic              sck_i,
    input  logic              ss_i,
    output logic              mosi_o,
    output logic              mosi_oe,
    output logic              miso_o,
    output logic              miso_oe,
    output logic              sck_o,
    output logic              sck_oe,
    output logic [NUM_SS-1:0] ss_o,
    output logic              ss_oe,
    output logic              data_in,
    output logic              sck_in,
    output logic              sck_rise,
    output logic              sck_fall,
    output logic              ss_slave,
    output logic              xfer_go,
    output logic              busy,
    output logic              modf,
    output logic              mstr_eff
);

    logic       ss_sync, mosi_sync, miso_sync;
    logic [2:0] unused_rise, unused_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST_SCK)) u_sync_sck (
        .clk(clk), .rst(rst), .d(sck_i), .q(sck_in), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST_SS)) u_sync_ss (
        .clk(clk), .rst(rst), .d(ss_i), .q(ss_sync), .rise(unused_rise[0]), .fall(unused_fall[0]));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST_DAT)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi_i), .q(mosi_sync), .rise(unused_rise[1]), .fall(unused_fall[1]));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST_DAT)) u_sync_miso (
        .clk(clk), .rst(rst), .d(miso_i), .q(miso_sync), .rise(unused_rise[2]), .fall(unused_fall[2]));

    spi_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NUM_SS-1:0] ss_o_q, ss_o_d;
    logic              xfer_go_q, xfer_go_d;
    logic              modf_q, modf_d;
    pad_drv_t          pad_q, pad_d;
    logic              fault, eff_n;
    logic [31:0]       idx_ext;

    // Drive decisions use the post-fault master state so that a fault releases
    // every pad enable in the same cycle modf becomes visible.
    always_comb begin
        fault  = mstr & modfen & ~ssoe & ~ss_sync;
        modf_d = fault | (modf_q & ~modf_clr);
        eff_n  = mstr & ~modf_d;

        pad_d         = '0;
        pad_d.mosi_o  = data_out;
        pad_d.miso_o  = data_out;
        pad_d.sck_o   = sck_out;
        pad_d.mosi_oe = eff_n;
        pad_d.sck_oe  = eff_n;
        pad_d.ss_oe   = eff_n & ssoe;
        // A faulted master is not a selected slave, so MISO needs mstr low too.
        pad_d.miso_oe = ~mstr & ~ss_sync;
        pad_d.data_in = eff_n ? miso_sync : mosi_sync;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ss_o_d    = ss_o_q;
        xfer_go_d = 1'b0;
        idx_ext   = 32'(ss_idx);
        case (state_q)
            ST_IDLE: begin
                if (xfer_req && (idx_ext < NUM_SS)) begin
                    for (int i = 0; i < NUM_SS; i++) ss_o_d[i] = (i != idx_ext);
                    cnt_d   = 8'(SS_SETUP_CYC - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    xfer_go_d = 1'b1;
                    state_d   = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (shift_done) begin
                    cnt_d   = 8'(SS_HOLD_CYC - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    ss_o_d  = '1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Losing master (fault or mode switch) aborts any sequence immediately.
        if (!eff_n) begin
            state_d   = ST_IDLE;
            ss_o_d    = '1;
            xfer_go_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ss_o_q    <= '1;
            xfer_go_q <= 1'b0;
            modf_q    <= 1'b0;
            pad_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ss_o_q    <= ss_o_d;
            xfer_go_q <= xfer_go_d;
            modf_q    <= modf_d;
            pad_q     <= pad_d;
        end
    end

    assign mosi_o   = pad_q.mosi_o;
    assign mosi_oe  = pad_q.mosi_oe;
    assign miso_o   = pad_q.miso_o;
    assign miso_oe  = pad_q.miso_oe;
    assign sck_o    = pad_q.sck_o;
    assign sck_oe   = pad_q.sck_oe;
    assign ss_oe    = pad_q.ss_oe;
    assign data_in  = pad_q.data_in;
    assign ss_o     = ss_o_q;
    assign xfer_go  = xfer_go_q;
    assign busy     = (state_q != ST_IDLE);
    assign modf     = modf_q;
    assign mstr_eff = mstr & ~modf_q;
    assign ss_slave = ss_sync | mstr_eff;

endmodule

// File: tb/tb_spi_port_ctrl_mc.sv
// Directed bench: master sequencing, slave steering and edges, mode fault,
// out-of-range select (on a 5-select instance) and reset mid-transfer.
module tb_spi_port_ctrl_mc;

    logic clk = 1'b0;
    logic rst, mstr, modfen, ssoe, xfer_req, xfer_req5, shift_done;
    logic sck_out, data_out, modf_clr, mosi_i, miso_i, sck_i, ss_i;
    logic [1:0] ss_idx;
    logic [2:0] ss_idx5;

    logic mosi_o, mosi_oe, miso_o, miso_oe, sck_o, sck_oe, ss_oe, data_in;
    logic sck_in, sck_rise, sck_fall, ss_slave, xfer_go, busy, modf, mstr_eff;
    logic [3:0] ss_o;

    logic mosi_o5, mosi_oe5, miso_o5, miso_oe5, sck_o5, sck_oe5, ss_oe5, data_in5;
    logic sck_in5, sck_rise5, sck_fall5, ss_slave5, xfer_go5, busy5, modf5, mstr_eff5;
    logic [4:0] ss_o5;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_port_ctrl_mc #(.NUM_SS(4), .SYNC_STAGES(2), .SS_SETUP_CYC(2), .SS_HOLD_CYC(3)) u_dut (
        .clk(clk), .rst(rst), .mstr(mstr), .modfen(modfen), .ssoe(ssoe), .ss_idx(ss_idx),
        .xfer_req(xfer_req), .shift_done(shift_done), .sck_out(sck_out), .data_out(data_out),
        .modf_clr(modf_clr), .mosi_i(mosi_i), .miso_i(miso_i), .sck_i(sck_i), .ss_i(ss_i),
        .mosi_o(mosi_o), .mosi_oe(mosi_oe), .miso_o(miso_o), .miso_oe(miso_oe),
        .sck_o(sck_o), .sck_oe(sck_oe), .ss_o(ss_o), .ss_oe(ss_oe), .data_in(data_in),
        .sck_in(sck_in), .sck_rise(sck_rise), .sck_fall(sck_fall), .ss_slave(ss_slave),
        .xfer_go(xfer_go), .busy(busy), .modf(modf), .mstr_eff(mstr_eff));

    spi_port_ctrl_mc #(.NUM_SS(5), .SYNC_STAGES(2), .SS_SETUP_CYC(2), .SS_HOLD_CYC(3)) u_dut5 (
        .clk(clk), .rst(rst), .mstr(mstr), .modfen(modfen), .ssoe(ssoe), .ss_idx(ss_idx5),
        .xfer_req(xfer_req5), .shift_done(shift_done), .sck_out(sck_out), .data_out(data_out),
        .modf_clr(modf_clr), .mosi_i(mosi_i), .miso_i(miso_i), .sck_i(sck_i), .ss_i(ss_i),
        .mosi_o(mosi_o5), .mosi_oe(mosi_oe5), .miso_o(miso_o5), .miso_oe(miso_oe5),
        .sck_o(sck_o5), .sck_oe(sck_oe5), .ss_o(ss_o5), .ss_oe(ss_oe5), .data_in(data_in5),
        .sck_in(sck_in5), .sck_rise(sck_rise5), .sck_fall(sck_fall5), .ss_slave(ss_slave5),
        .xfer_go(xfer_go5), .busy(busy5), .modf(modf5), .mstr_eff(mstr_eff5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mstr = 1'b0; modfen = 1'b0; ssoe = 1'b0; ss_idx = 2'd0; ss_idx5 = 3'd0;
        xfer_req = 1'b0; xfer_req5 = 1'b0; shift_done = 1'b0; sck_out = 1'b0; data_out = 1'b0;
        modf_clr = 1'b0; mosi_i = 1'b0; miso_i = 1'b0; sck_i = 1'b0; ss_i = 1'b1;
        step(3);
        chk("rst_ss_o", 32'(ss_o), 32'hF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_xfer_go", 32'(xfer_go), 0);
        chk("rst_modf", 32'(modf), 0);
        chk("rst_oe", 32'({mosi_oe, sck_oe, ss_oe, miso_oe}), 0);
        chk("rst_edges", 32'({sck_rise, sck_fall}), 0);

        // master steering
        rst = 1'b0; mstr = 1'b1; ssoe = 1'b1; data_out = 1'b1; sck_out = 1'b1; miso_i = 1'b1;
        step(4);
        chk("m_oe", 32'({mosi_oe, sck_oe, ss_oe, miso_oe}), 32'b1110);
        chk("m_drive", 32'({mosi_o, sck_o}), 32'b11);
        chk("m_data_in", 32'(data_in), 1);
        chk("m_eff_ssl", 32'({mstr_eff, ss_slave}), 32'b11);
        shift_done = 1'b1; step(1); shift_done = 1'b0;
        chk("idle_done_ign", 32'(busy), 0);

        // auto-SS sequence, idx 2
        ss_idx = 2'd2; xfer_req = 1'b1; step(1); xfer_req = 1'b0;
        chk("seq_ss_low", 32'(ss_o), 32'b1011);
        chk("seq_busy", 32'(busy), 1);
        chk("seq_go0", 32'(xfer_go), 0);
        step(1); chk("seq_go1", 32'(xfer_go), 0);
        step(1); chk("seq_go2", 32'(xfer_go), 1);
        ss_idx = 2'd0; xfer_req = 1'b1; step(1); xfer_req = 1'b0;
        chk("seq_go_pulse", 32'(xfer_go), 0);
        chk("seq_req_ign", 32'(ss_o), 32'b1011);
        step(2);
        shift_done = 1'b1; step(1); shift_done = 1'b0;
        chk("hold_h0", 32'(ss_o), 32'b1011);
        step(2);
        chk("hold_h2", 32'({busy, ss_o}), 32'b11011);
        step(1);
        chk("hold_rel", 32'({busy, ss_o}), 32'b01111);

        // out-of-range select on 5-select instance, then top index
        ss_idx5 = 3'd5; xfer_req5 = 1'b1; step(1); xfer_req5 = 1'b0;
        chk("oor_ss", 32'(ss_o5), 32'h1F);
        chk("oor_busy", 32'(busy5), 0);
        for (int i = 0; i < 4; i++) begin
            step(1); chk("oor_go", 32'({xfer_go5, busy5}), 0);
        end
        ss_idx5 = 3'd4; xfer_req5 = 1'b1; step(1); xfer_req5 = 1'b0;
        chk("top_idx_ss", 32'(ss_o5), 32'b01111);

        // reset during SETUP
        ss_idx = 2'd3; xfer_req = 1'b1; step(1); xfer_req = 1'b0;
        chk("rs_ss_low", 32'(ss_o), 32'b0111);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rs_ss", 32'(ss_o), 32'hF);
        chk("rs_busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            step(1); chk("rs_no_go", 32'(xfer_go), 0);
        end

        // mode fault mid-ACTIVE
        ssoe = 1'b0; modfen = 1'b1; step(2);
        ss_idx = 2'd1; xfer_req = 1'b1; step(1); xfer_req = 1'b0;
        chk("mf_ss_low", 32'(ss_o), 32'b1101);
        step(3); chk("mf_active", 32'(busy), 1);
        ss_i = 1'b0; step(2);
        chk("mf_pre", 32'({modf, mstr_eff, ss_slave}), 32'b011);
        step(1);
        chk("mf_set", 32'({modf, mstr_eff}), 32'b10);
        chk("mf_oe", 32'({mosi_oe, sck_oe, ss_oe, miso_oe}), 0);
        chk("mf_ss_busy", 32'({busy, ss_o}), 32'b01111);
        modf_clr = 1'b1; step(1); modf_clr = 1'b0;
        chk("mf_set_wins", 32'(modf), 1);
        ss_i = 1'b1; step(3);
        chk("mf_sticky", 32'(modf), 1);
        modf_clr = 1'b1; step(1); modf_clr = 1'b0;
        chk("mf_clr", 32'({modf, mstr_eff, mosi_oe}), 32'b011);

        // mode switch while busy
        ss_idx = 2'd0; xfer_req = 1'b1; step(1); xfer_req = 1'b0;
        chk("sw_ss_low", 32'(ss_o), 32'b1110);
        mstr = 1'b0; modfen = 1'b0; step(1);
        chk("sw_idle", 32'({busy, ss_o}), 32'b01111);

        // slave mode: sck edges and selected MISO drive
        step(3);
        chk("s_oe", 32'({mstr_eff, mosi_oe, sck_oe, ss_oe, miso_oe}), 0);
        sck_i = 1'b1; step(1);
        chk("s_rise_e1", 32'(sck_rise), 0);
        step(1);
        chk("s_rise", 32'({sck_rise, sck_fall, sck_in}), 32'b101);
        sck_i = 1'b0; step(1);
        chk("s_quiet", 32'({sck_rise, sck_fall}), 0);
        step(1);
        chk("s_fall", 32'({sck_rise, sck_fall, sck_in}), 32'b010);
        step(1);
        chk("s_fall_end", 32'(sck_fall), 0);
        ss_i = 1'b0; mosi_i = 1'b1; step(2);
        chk("s_sel_sync", 32'({ss_slave, miso_oe}), 0);
        step(1);
        chk("s_sel_drive", 32'({miso_oe, data_in, miso_o}), 32'b111);
        ss_i = 1'b1; step(2);
        chk("s_desel_lag", 32'(miso_oe), 1);
        step(1);
        chk("s_desel", 32'(miso_oe), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
